// File: rtl/switch_pkg.sv
// Shared constants and types for the switch debounce stage.
package switch_pkg;

  // 10 ms at 25 MHz
  localparam int unsigned DEBOUNCE_STABLE_CYCLES = 250000;

  // Short interval so that benches finish quickly
  localparam int unsigned SIM_STABLE_CYCLES = 4;

  // Per-channel debounce state. The state is implied by comparing the
  // synchronised input with the held level; it is not stored separately.
  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_COUNTING = 1'b1
  } debounce_state_e;

  // Counter width. It must hold values up to STABLE_CYCLES-1, which
  // $clog2(STABLE_CYCLES) covers. The result is clamped to at least one bit.
  function automatic int unsigned cnt_width(input int unsigned stable_cycles);
    int unsigned w;
    w = $clog2(stable_cycles);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage : switch_pkg

// File: rtl/switch_debounce_chan.sv
// One debounce channel: a two-flop synchroniser, a stability counter,
// the held (clean) level, and registered rise/fall pulses.
module switch_debounce_chan
  import switch_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEBOUNCE_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_raw,
  output logic sw_out,
  output logic sw_rise,
  output logic sw_fall
);

  localparam int unsigned      CNT_W = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] TERM  = CNT_W'(STABLE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;

  debounce_state_e  w_state;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_level_nxt;
  logic             w_rise_nxt;
  logic             w_fall_nxt;

  // Two-flop synchroniser with no logic between the stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= sw_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce state register: counter, held level and pulse outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // Next-state logic. The counter clears as soon as the input agrees with
  // the held level again, which rejects bounces. The held level is updated
  // only when the counter reaches terminal count.
  always_comb begin
    w_state     = (r_sync2 != r_level) ? ST_COUNTING : ST_IDLE;
    w_cnt_nxt   = '0;
    w_level_nxt = r_level;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    unique case (w_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
      end
      ST_COUNTING: begin
        if (r_cnt == TERM) begin
          w_cnt_nxt   = '0;
          w_level_nxt = r_sync2;
          w_rise_nxt  = r_sync2;
          w_fall_nxt  = ~r_sync2;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_cnt_nxt = '0;
      end
    endcase
  end

  assign sw_out  = r_level;
  assign sw_rise = r_rise;
  assign sw_fall = r_fall;

endmodule : switch_debounce_chan

// File: rtl/switch_debounce.sv
// Debounces NUM_SW raw switch inputs into clean levels and edge pulses.
// Every channel is fully independent of the others.
module switch_debounce
  import switch_pkg::*;
#(
  parameter int unsigned NUM_SW        = 2,
  parameter int unsigned STABLE_CYCLES = DEBOUNCE_STABLE_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_SW-1:0] sw_raw,
  output logic [NUM_SW-1:0] sw_out,
  output logic [NUM_SW-1:0] sw_rise,
  output logic [NUM_SW-1:0] sw_fall
);

  // One debounce channel per switch
  for (genvar g = 0; g < NUM_SW; g++) begin : g_chan
    switch_debounce_chan #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .sw_raw (sw_raw[g]),
      .sw_out (sw_out[g]),
      .sw_rise(sw_rise[g]),
      .sw_fall(sw_fall[g])
    );
  end

endmodule : switch_debounce

// File: tb/tb_switch_debounce.sv
// Scoreboard bench for switch_debounce with STABLE_CYCLES=4 and NUM_SW=2.
// Each queue entry holds the inputs for one clock edge and the outputs
// expected right after that edge.
module tb_switch_debounce;
  import switch_pkg::*;

  localparam int unsigned NSW = 2;

  typedef struct packed {
    logic [NSW-1:0] raw;
    logic           rst;
    logic [NSW-1:0] out;
    logic [NSW-1:0] rise;
    logic [NSW-1:0] fall;
  } item_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [NSW-1:0] sw_raw;
  logic [NSW-1:0] sw_out;
  logic [NSW-1:0] sw_rise;
  logic [NSW-1:0] sw_fall;

  int    tests_run    = 0;
  int    tests_failed = 0;
  item_t exp_q[$];

  switch_debounce #(
    .NUM_SW       (NSW),
    .STABLE_CYCLES(SIM_STABLE_CYCLES)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sw_raw (sw_raw),
    .sw_out (sw_out),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall)
  );

  always #5 clk = ~clk;

  // Queue n identical cycles of stimulus and expectation
  task automatic push_n(input int n, input logic [NSW-1:0] raw, input logic r,
                        input logic [NSW-1:0] out, input logic [NSW-1:0] rise,
                        input logic [NSW-1:0] fall);
    item_t it;
    it.raw = raw; it.rst = r; it.out = out; it.rise = rise; it.fall = fall;
    for (int i = 0; i < n; i++) exp_q.push_back(it);
  endtask

  // Apply inputs, then let one rising edge pass and settle
  task automatic drive_and_tick(input item_t it);
    sw_raw = it.raw;
    rst    = it.rst;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    item_t it;
    int    cyc = 0;
    push_n(5, 2'b11, 1'b1, 2'b00, 2'b00, 2'b00);
    while (exp_q.size() > 0) begin
      it = exp_q.pop_front();
      drive_and_tick(it);
      cyc++;
      tests_run++;
      if ({sw_out, sw_rise, sw_fall} !== {it.out, it.rise, it.fall}) begin
        tests_failed++;
        $display("FAIL reset cyc=%0d out/rise/fall got %b/%b/%b exp %b/%b/%b",
                 cyc, sw_out, sw_rise, sw_fall, it.out, it.rise, it.fall);
      end
    end
  endtask

  task automatic test_clean_press();
    item_t it;
    int    cyc = 0;
    push_n(5, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00);
    push_n(1, 2'b01, 1'b0, 2'b01, 2'b01, 2'b00);
    push_n(3, 2'b01, 1'b0, 2'b01, 2'b00, 2'b00);
    while (exp_q.size() > 0) begin
      it = exp_q.pop_front();
      drive_and_tick(it);
      cyc++;
      tests_run++;
      if ({sw_out, sw_rise, sw_fall} !== {it.out, it.rise, it.fall}) begin
        tests_failed++;
        $display("FAIL clean_press edge=%0d out/rise/fall got %b/%b/%b exp %b/%b/%b",
                 cyc, sw_out, sw_rise, sw_fall, it.out, it.rise, it.fall);
      end
    end
  endtask

  task automatic test_bounce_reject();
    item_t it;
    int    cyc = 0;
    push_n(2, 2'b11, 1'b0, 2'b01, 2'b00, 2'b00);
    push_n(2, 2'b01, 1'b0, 2'b01, 2'b00, 2'b00);
    push_n(2, 2'b11, 1'b0, 2'b01, 2'b00, 2'b00);
    push_n(8, 2'b01, 1'b0, 2'b01, 2'b00, 2'b00);
    while (exp_q.size() > 0) begin
      it = exp_q.pop_front();
      drive_and_tick(it);
      cyc++;
      tests_run++;
      if ({sw_out, sw_rise, sw_fall} !== {it.out, it.rise, it.fall}) begin
        tests_failed++;
        $display("FAIL bounce_reject edge=%0d out/rise/fall got %b/%b/%b exp %b/%b/%b",
                 cyc, sw_out, sw_rise, sw_fall, it.out, it.rise, it.fall);
      end
    end
  endtask

  // Stand-in for the downstream AND of in_a/in_b fed from sw_out
  task automatic test_integration();
    item_t it;
    int    cyc = 0;
    push_n(5, 2'b11, 1'b0, 2'b01, 2'b00, 2'b00);
    push_n(1, 2'b11, 1'b0, 2'b11, 2'b10, 2'b00);
    push_n(2, 2'b11, 1'b0, 2'b11, 2'b00, 2'b00);
    while (exp_q.size() > 0) begin
      it = exp_q.pop_front();
      drive_and_tick(it);
      cyc++;
      tests_run++;
      if ({sw_out, sw_rise, sw_fall} !== {it.out, it.rise, it.fall}) begin
        tests_failed++;
        $display("FAIL integration edge=%0d out/rise/fall got %b/%b/%b exp %b/%b/%b",
                 cyc, sw_out, sw_rise, sw_fall, it.out, it.rise, it.fall);
      end
      tests_run++;
      if ((sw_out[0] & sw_out[1]) !== (it.out[0] & it.out[1])) begin
        tests_failed++;
        $display("FAIL integration_and edge=%0d got %b exp %b",
                 cyc, sw_out[0] & sw_out[1], it.out[0] & it.out[1]);
      end
    end
  endtask

  task automatic test_release_simultaneous();
    item_t it;
    int    cyc = 0;
    push_n(5, 2'b00, 1'b0, 2'b11, 2'b00, 2'b00);
    push_n(1, 2'b00, 1'b0, 2'b00, 2'b00, 2'b11);
    push_n(3, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00);
    while (exp_q.size() > 0) begin
      it = exp_q.pop_front();
      drive_and_tick(it);
      cyc++;
      tests_run++;
      if ({sw_out, sw_rise, sw_fall} !== {it.out, it.rise, it.fall}) begin
        tests_failed++;
        $display("FAIL release_simul edge=%0d out/rise/fall got %b/%b/%b exp %b/%b/%b",
                 cyc, sw_out, sw_rise, sw_fall, it.out, it.rise, it.fall);
      end
    end
  endtask

  // High 3, low 1, then steady high: final rise sampled at edge 5,
  // sw_out rises at edge 10
  task automatic test_bounce_settle();
    item_t it;
    int    cyc = 0;
    push_n(3, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00);
    push_n(1, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00);
    push_n(5, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00);
    push_n(1, 2'b01, 1'b0, 2'b01, 2'b01, 2'b00);
    push_n(3, 2'b01, 1'b0, 2'b01, 2'b00, 2'b00);
    while (exp_q.size() > 0) begin
      it = exp_q.pop_front();
      drive_and_tick(it);
      cyc++;
      tests_run++;
      if ({sw_out, sw_rise, sw_fall} !== {it.out, it.rise, it.fall}) begin
        tests_failed++;
        $display("FAIL bounce_settle edge=%0d out/rise/fall got %b/%b/%b exp %b/%b/%b",
                 cyc, sw_out, sw_rise, sw_fall, it.out, it.rise, it.fall);
      end
    end
  endtask

  // Release channel 0, press again, reset while the counter sits at 2;
  // rise must come 6 edges after reset deasserts
  task automatic test_reset_midcount();
    item_t it;
    int    cyc = 0;
    push_n(5, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00);
    push_n(1, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01);
    push_n(2, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00);
    push_n(4, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00);
    push_n(1, 2'b01, 1'b1, 2'b00, 2'b00, 2'b00);
    push_n(5, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00);
    push_n(1, 2'b01, 1'b0, 2'b01, 2'b01, 2'b00);
    push_n(2, 2'b01, 1'b0, 2'b01, 2'b00, 2'b00);
    while (exp_q.size() > 0) begin
      it = exp_q.pop_front();
      drive_and_tick(it);
      cyc++;
      tests_run++;
      if ({sw_out, sw_rise, sw_fall} !== {it.out, it.rise, it.fall}) begin
        tests_failed++;
        $display("FAIL reset_midcount step=%0d out/rise/fall got %b/%b/%b exp %b/%b/%b",
                 cyc, sw_out, sw_rise, sw_fall, it.out, it.rise, it.fall);
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    sw_raw = 2'b11;
    test_reset();
    test_clean_press();
    test_bounce_reject();
    test_integration();
    test_release_simultaneous();
    test_bounce_settle();
    test_reset_midcount();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_switch_debounce
